ma_stage: RTL and testbench



---
 rtl/ma_stage_if.sv | 47 ++++
 rtl/ma_stage.sv | 107 ++++++++++
 tb/tb_ma_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ma_stage_if.sv
// Bundle of the ma_stage handshakes: execute->stage, stage->writeback and
// stage->data memory. master = the stage itself, slave = its environment.
interface ma_stage_if #(
    parameter int ADDR_W = 32
);
    // execute -> stage
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       Alu_Result;
    logic [31:0]       op2;
    logic              IsLd;
    logic              IsSt;
    logic              IsWb;
    logic [3:0]        rd;
    logic [31:0]       pc;
    // stage -> writeback
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_alu;
    logic [31:0]       out_ld;
    logic [3:0]        out_rd;
    logic              out_IsWb;
    logic              out_IsLd;
    logic [31:0]       out_pc;
    logic              out_err;
    // stage -> data memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        input  in_valid, Alu_Result, op2, IsLd, IsSt, IsWb, rd, pc,
        input  out_ready, mem_rdata, mem_ack,
        output in_ready, out_valid, out_alu, out_ld, out_rd, out_IsWb, out_IsLd,
        output out_pc, out_err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, Alu_Result, op2, IsLd, IsSt, IsWb, rd, pc,
        output out_ready, mem_rdata, mem_ack,
        input  in_ready, out_valid, out_alu, out_ld, out_rd, out_IsWb, out_IsLd,
        input  out_pc, out_err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ma_stage.sv
// SimpleRisc memory-access stage: one instruction in flight, req/ack data memory,
// valid/ready result to writeback. Define ALIGN_CHECK_EN to reject misaligned ld/st.
module ma_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    ma_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] toCnt;
    logic       accept;
    logic       isMem;
    logic       misalign;

    assign bus.in_ready = (state == IDLE) || (state == HOLD && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign isMem        = bus.IsLd || bus.IsSt;

`ifdef ALIGN_CHECK_EN
    assign misalign = isMem && (bus.Alu_Result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            toCnt         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_alu   <= '0;
            bus.out_ld    <= '0;
            bus.out_rd    <= '0;
            bus.out_IsWb  <= 1'b0;
            bus.out_IsLd  <= 1'b0;
            bus.out_pc    <= '0;
            bus.out_err   <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        bus.out_alu  <= bus.Alu_Result;
                        bus.out_rd   <= bus.rd;
                        bus.out_IsLd <= bus.IsLd;
                        bus.out_pc   <= bus.pc;
                        bus.out_ld   <= '0;
                        toCnt        <= '0;
                        if (misalign) begin
                            state         <= HOLD;
                            bus.out_valid <= 1'b1;
                            bus.out_err   <= 1'b1;
                            bus.out_IsWb  <= 1'b0;
                        end else if (isMem) begin
                            // a combined ld+st is treated as a load, so never a write
                            state         <= ACCESS;
                            bus.out_valid <= 1'b0;
                            bus.out_err   <= 1'b0;
                            bus.out_IsWb  <= bus.IsWb;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.IsSt && !bus.IsLd;
                            bus.mem_addr  <= ADDR_W'(bus.Alu_Result);
                            bus.mem_wdata <= bus.op2;
                        end else begin
                            state         <= HOLD;
                            bus.out_valid <= 1'b1;
                            bus.out_err   <= 1'b0;
                            bus.out_IsWb  <= bus.IsWb;
                        end
                    end else if (state == HOLD && bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                ACCESS: begin
                    // ack beats a timeout landing on the same edge
                    if (bus.mem_ack) begin
                        state         <= HOLD;
                        bus.out_valid <= 1'b1;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        if (bus.out_IsLd) bus.out_ld <= bus.mem_rdata;
                    end else if (toCnt == TO_LAST) begin
                        state         <= HOLD;
                        bus.out_valid <= 1'b1;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.out_err   <= 1'b1;
                        bus.out_IsWb  <= 1'b0;
                        bus.out_ld    <= '0;
                    end else begin
                        toCnt <= toCnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ma_stage.sv
// Randomized bench for ma_stage: transaction-level model of the stage plus a
// memory responder with random latency, spurious acks and back-pressure.
module tb_ma_stage;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ma_stage_if #(.ADDR_W(32)) bus ();

    ma_stage #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, op2, pc, ld;
        logic [3:0]  rd;
        logic        isLd, isSt, isWb, err, done;
    } instr_t;

    instr_t      expQ[$];
    instr_t      pendInstr;
    bit          pend = 0;
    bit          memBusy = 0;
    int          memCnt = 0;
    int          memLat = 0;
    logic [31:0] memData = '0;
    int          readyBias = 9;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic instr_t randInstr();
        instr_t i;
        int k = $urandom_range(0, 7);
        i.alu  = $urandom;
        i.op2  = $urandom;
        i.pc   = $urandom;
        i.rd   = 4'($urandom);
        i.isWb = 1'($urandom);
        i.isLd = (k >= 4 && k <= 5) || k == 7;
        i.isSt = (k >= 6);
        if ((i.isLd || i.isSt) && $urandom_range(0, 3) != 0) i.alu[1:0] = 2'b00;
        i.ld   = '0;
        i.err  = 1'b0;
        i.done = 1'b0;
        return i;
    endfunction

    task automatic driveInstr(input instr_t i);
        bus.Alu_Result = i.alu;
        bus.op2        = i.op2;
        bus.pc         = i.pc;
        bus.rd         = i.rd;
        bus.IsWb       = i.isWb;
        bus.IsLd       = i.isLd;
        bus.IsSt       = i.isSt;
    endtask

    // Outcome of an accepted instruction as seen by writeback.
    function automatic instr_t onAccept(input instr_t i);
        instr_t e = i;
        e.ld  = '0;
        e.err = 1'b0;
        e.done = !(i.isLd || i.isSt);
`ifdef ALIGN_CHECK_EN
        if ((i.isLd || i.isSt) && i.alu[1:0] != 2'b00) begin
            e.done = 1'b1;
            e.err  = 1'b1;
            e.isWb = 1'b0;
        end
`endif
        return e;
    endfunction

    task automatic step();
        bit readyExp, validExp, fire;
        @(negedge clk);
        // memory responder; expQ[$] is the only instruction that can own the request
        if (bus.mem_req) begin
            if (!memBusy) begin
                memBusy = 1;
                memCnt  = 0;
                memLat  = $urandom_range(1, 6);
                memData = $urandom;
                if (expQ.size() == 0) chk("req_without_instr", bus.mem_req, 0);
                else begin
                    chk("req_for_memop", bus.mem_req, !expQ[$].done);
                    chk("mem_addr", bus.mem_addr, expQ[$].alu);
                    chk("mem_we", bus.mem_we, expQ[$].isSt && !expQ[$].isLd);
                    chk("mem_wdata", bus.mem_wdata, expQ[$].op2);
                end
            end else if (expQ.size() > 0) begin
                chk("mem_addr_stable", bus.mem_addr, expQ[$].alu);
            end
            memCnt++;
            bus.mem_ack = (memCnt == memLat);
        end else begin
            if (memBusy) begin
                memBusy = 0;
                chk("req_cycles", memCnt, (memLat <= TO) ? memLat : TO);
                if (expQ.size() > 0) begin
                    expQ[$].done = 1'b1;
                    if (memLat <= TO) begin
                        expQ[$].ld = expQ[$].isLd ? memData : 32'h0;
                    end else begin
                        expQ[$].err  = 1'b1;
                        expQ[$].isWb = 1'b0;
                    end
                end
            end
            bus.mem_ack = ($urandom_range(0, 3) == 0);
        end
        bus.mem_rdata = bus.mem_ack ? memData : $urandom;

        if (!pend && $urandom_range(0, 3) != 0) begin
            pendInstr = randInstr();
            pend = 1;
        end
        bus.in_valid  = pend;
        driveInstr(pendInstr);
        bus.out_ready = ($urandom_range(0, 9) < readyBias);
        #1;

        validExp = (expQ.size() > 0) && expQ[0].done;
        readyExp = (expQ.size() == 0) || (validExp && bus.out_ready);
        chk("in_ready", bus.in_ready, readyExp);
        chk("out_valid", bus.out_valid, validExp);
        if (validExp && bus.out_valid) begin
            chk("out_alu", bus.out_alu, expQ[0].alu);
            chk("out_ld", bus.out_ld, expQ[0].ld);
            chk("out_rd", bus.out_rd, expQ[0].rd);
            chk("out_IsWb", bus.out_IsWb, expQ[0].isWb);
            chk("out_IsLd", bus.out_IsLd, expQ[0].isLd);
            chk("out_pc", bus.out_pc, expQ[0].pc);
            chk("out_err", bus.out_err, expQ[0].err);
        end
        fire = validExp && bus.out_valid && bus.out_ready;
        if (fire) void'(expQ.pop_front());
        if (bus.in_valid && bus.in_ready) begin
            expQ.push_back(onAccept(pendInstr));
            pend = 0;
        end
    endtask

    initial begin
        instr_t d;
        bus.in_valid = 0; bus.out_ready = 0; bus.mem_ack = 1; bus.mem_rdata = '0;
        pendInstr = randInstr();
        driveInstr(pendInstr);
        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_out_alu", bus.out_alu, 0);
        chk("rst_out_ld", bus.out_ld, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst_n = 1;   // stale ack still high on the first edge after release

        for (int c = 0; c < 4000; c++) begin
            readyBias = ((c / 150) % 2 == 0) ? 9 : 3;
            step();
        end

        // reset while a load is outstanding
        @(negedge clk);
        rst_n = 0; bus.in_valid = 0; bus.mem_ack = 0;
        @(negedge clk);
        rst_n = 1;
        expQ.delete(); pend = 0; memBusy = 0;
        d = randInstr();
        d.alu = 32'h100; d.isLd = 1; d.isSt = 0; d.isWb = 1;
        driveInstr(d);
        bus.in_valid = 1; bus.out_ready = 1;
        #1 chk("ld_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 0;
        #1 chk("ld_mem_req", bus.mem_req, 1);
        chk("ld_mem_addr", bus.mem_addr, 32'h100);
        chk("ld_in_ready_busy", bus.in_ready, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk("async_rst_mem_req", bus.mem_req, 0);
        chk("async_rst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1; bus.mem_ack = 1;
        #1 chk("post_rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.mem_ack = 0;
        #1 chk("stale_ack_mem_req", bus.mem_req, 0);
        chk("stale_ack_out_valid", bus.out_valid, 0);

`ifdef ALIGN_CHECK_EN
        d.alu = 32'h102;
        driveInstr(d);
        bus.in_valid = 1;
        @(negedge clk);
        bus.in_valid = 0;
        #1 chk("misalign_mem_req", bus.mem_req, 0);
        chk("misalign_out_valid", bus.out_valid, 1);
        chk("misalign_out_err", bus.out_err, 1);
        chk("misalign_out_IsWb", bus.out_IsWb, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
